// File: rtl/sd_pkg.sv
// Shared definitions for the SD host controller CMD-line logic:
// response type encodings, frame lengths, CRC7 polynomial, receiver
// FSM states and a single-bit CRC7 update helper.
package sd_pkg;

    typedef enum logic [1:0] {
        RESP_NONE     = 2'd0,
        RESP_48_CRC   = 2'd1,
        RESP_136      = 2'd2,
        RESP_48_NOCRC = 2'd3
    } resp_type_e;

    localparam int RESP_LEN_48  = 48;
    localparam int RESP_LEN_136 = 136;

    // x^7 + x^3 + 1 with the x^7 term implied
    localparam logic [6:0] CRC7_POLY = 7'h09;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_START = 2'd1,
        ST_RECV       = 2'd2,
        ST_CHECK      = 2'd3
    } rx_state_e;

    // Advance a serial CRC7 (MSB-first) by one input bit.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        crc7_step = {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 generator/checker, zero seed, one bit per enabled clk.
// Shared between the command sender and the response receiver.
module sd_crc7
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    logic [6:0] crc_r;

    // CRC state: clear has priority over accumulate.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            crc_r <= 7'h00;
        end else if (clr) begin
            crc_r <= 7'h00;
        end else if (en) begin
            crc_r <= crc7_step(crc_r, din);
        end else begin
            crc_r <= crc_r;
        end
    end

    assign crc = crc_r;

endmodule

// File: rtl/sd_cmd_resp_rx.sv
// SD CMD-line response receiver. Armed after a command is sent, waits for
// the card's start bit (bounded by TIMEOUT_CYCLES SD clocks), shifts in a
// 48- or 136-bit response and checks transmission bit, end bit, CRC7 and
// optionally the command index.
// Optional feature macro: SD_CMD_RESP_INDEX_CHECK_EN (index_err for R1-type
// responses); when undefined index_err is tied low.
module sd_cmd_resp_rx
    import sd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int SYNC_STAGES    = 2
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         sd_clk_en,
    input  logic         cmd_pin,
    input  logic         arm,
    input  logic         abort,
    input  logic [1:0]   resp_type,
    input  logic [5:0]   exp_index,
    output logic         busy,
    output logic         done,
    output logic [5:0]   resp_index,
    output logic [127:0] resp_data,
    output logic         timeout_err,
    output logic         crc_err,
    output logic         frame_err,
    output logic         index_err
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    rx_state_e              state_r;
    rx_state_e              state_s;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   cmd_s;
    resp_type_e             type_r;
    resp_type_e             arm_type_s;
    logic [7:0]             bit_cnt_r;
    logic [7:0]             crc_hi_s;
    logic [TMR_W-1:0]       tmr_r;
    logic [135:0]           shift_r;
    logic                   accept_s;
    logic                   arm_none_s;
    logic                   sample_s;
    logic                   tmo_s;
    logic                   crc_en_s;
    logic [6:0]             crc_s;

    logic                   chk_crc_err_s;
    logic                   chk_frame_err_s;
    logic                   chk_index_err_s;
    logic [5:0]             chk_index_s;
    logic [127:0]           chk_data_s;

    logic                   busy_r;
    logic                   done_r;
    logic [5:0]             resp_index_r;
    logic [127:0]           resp_data_r;
    logic                   timeout_err_r;
    logic                   crc_err_r;
    logic                   frame_err_r;
    logic                   index_err_r;
    logic                   unused_s;

    assign cmd_s      = sync_r[SYNC_STAGES-1];
    assign arm_type_s = resp_type_e'(resp_type);
    // A new request is only taken from IDLE; abort in the same clk wins.
    assign accept_s   = arm && !abort && (state_r == ST_IDLE) && (arm_type_s != RESP_NONE);
    assign arm_none_s = arm && !abort && (state_r == ST_IDLE) && (arm_type_s == RESP_NONE);
    // A line sample is taken on the start bit and on every strobe while receiving.
    assign sample_s   = !abort && sd_clk_en &&
                        (((state_r == ST_WAIT_START) && !cmd_s) || (state_r == ST_RECV));
    // The start bit takes priority over the timeout on the final strobe.
    assign tmo_s      = !abort && sd_clk_en && (state_r == ST_WAIT_START) && cmd_s &&
                        (tmr_r == TMR_W'(TIMEOUT_CYCLES - 1));
    assign crc_hi_s   = (type_r == RESP_136) ? 8'd127 : 8'd47;
    assign crc_en_s   = sample_s && (bit_cnt_r >= 8'd8) && (bit_cnt_r <= crc_hi_s);

    // Metastability synchroniser for the CMD line, idle-high preset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], cmd_pin};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        if (abort) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_s = ST_WAIT_START;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_WAIT_START: begin
                    if (sample_s) begin
                        state_s = ST_RECV;
                    end else if (tmo_s) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_WAIT_START;
                    end
                end
                ST_RECV: begin
                    if (sample_s && (bit_cnt_r == 8'd0)) begin
                        state_s = ST_CHECK;
                    end else begin
                        state_s = ST_RECV;
                    end
                end
                ST_CHECK: begin
                    state_s = ST_IDLE;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // Request capture, NCR timer and frame shift register; bit_cnt_r holds the
    // frame index of the next bit to be sampled.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            type_r    <= RESP_NONE;
            bit_cnt_r <= 8'd0;
            tmr_r     <= {TMR_W{1'b0}};
            shift_r   <= 136'd0;
        end else if (accept_s) begin
            type_r    <= arm_type_s;
            bit_cnt_r <= (arm_type_s == RESP_136) ? 8'(RESP_LEN_136 - 1) : 8'(RESP_LEN_48 - 1);
            tmr_r     <= {TMR_W{1'b0}};
        end else if (sample_s) begin
            shift_r <= {shift_r[134:0], cmd_s};
            if (bit_cnt_r != 8'd0) begin
                bit_cnt_r <= bit_cnt_r - 8'd1;
            end
        end else if (!abort && sd_clk_en && (state_r == ST_WAIT_START)) begin
            tmr_r <= tmr_r + TMR_W'(1);
        end
    end

`ifdef SD_CMD_RESP_INDEX_CHECK_EN
    logic [5:0] exp_index_r;

    // Expected command index, latched with the request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            exp_index_r <= 6'd0;
        end else if (accept_s) begin
            exp_index_r <= exp_index;
        end
    end

    assign unused_s = ^{shift_r[135], shift_r[133:128]};
`else
    assign unused_s = ^{shift_r[135], shift_r[133:128], exp_index};
`endif

    sd_crc7 u_crc7 (
        .clk    (clk),
        .resetn (resetn),
        .clr    (accept_s),
        .en     (crc_en_s),
        .din    (cmd_s),
        .crc    (crc_s)
    );

    // Frame field extraction and error evaluation, used in the CHECK clk.
    always_comb begin
        chk_frame_err_s = 1'b0;
        chk_crc_err_s   = 1'b0;
        chk_index_err_s = 1'b0;
        chk_index_s     = 6'd0;
        chk_data_s      = 128'd0;
        if (type_r == RESP_136) begin
            chk_frame_err_s = shift_r[134] | ~shift_r[0];
            chk_index_s     = 6'h3F;
            chk_data_s      = {shift_r[127:1], 1'b0};
        end else begin
            chk_frame_err_s = shift_r[46] | ~shift_r[0];
            chk_index_s     = shift_r[45:40];
            chk_data_s      = {96'd0, shift_r[39:8]};
        end
        if ((type_r == RESP_48_CRC) || (type_r == RESP_136)) begin
            chk_crc_err_s = (crc_s != shift_r[7:1]);
        end else begin
            chk_crc_err_s = 1'b0;
        end
`ifdef SD_CMD_RESP_INDEX_CHECK_EN
        if (type_r == RESP_48_CRC) begin
            chk_index_err_s = (shift_r[45:40] != exp_index_r);
        end else begin
            chk_index_err_s = 1'b0;
        end
`else
        chk_index_err_s = 1'b0;
`endif
    end

    // Registered status/result outputs; results hold until the next request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            resp_index_r  <= 6'd0;
            resp_data_r   <= 128'd0;
            timeout_err_r <= 1'b0;
            crc_err_r     <= 1'b0;
            frame_err_r   <= 1'b0;
            index_err_r   <= 1'b0;
        end else begin
            busy_r <= (state_s != ST_IDLE);
            if (abort) begin
                done_r <= 1'b0;
            end else if (arm_none_s || accept_s) begin
                done_r        <= arm_none_s;
                timeout_err_r <= 1'b0;
                crc_err_r     <= 1'b0;
                frame_err_r   <= 1'b0;
                index_err_r   <= 1'b0;
            end else if (state_r == ST_CHECK) begin
                done_r        <= 1'b1;
                resp_index_r  <= chk_index_s;
                resp_data_r   <= chk_data_s;
                timeout_err_r <= 1'b0;
                crc_err_r     <= chk_crc_err_s;
                frame_err_r   <= chk_frame_err_s;
                index_err_r   <= chk_index_err_s;
            end else if (tmo_s) begin
                done_r        <= 1'b1;
                timeout_err_r <= 1'b1;
            end else begin
                done_r <= 1'b0;
            end
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign resp_index  = resp_index_r;
    assign resp_data   = resp_data_r;
    assign timeout_err = timeout_err_r;
    assign crc_err     = crc_err_r;
    assign frame_err   = frame_err_r;
    assign index_err   = index_err_r;

endmodule

// File: tb/tb_sd_cmd_resp_rx.sv
// Self-checking bench for sd_cmd_resp_rx: expected results are queued when
// a response is requested and compared whenever the receiver pulses done.
module tb_sd_cmd_resp_rx;

    logic         clk = 1'b0;
    logic         resetn;
    logic         sd_clk_en;
    logic         cmd_pin;
    logic         arm;
    logic         abort;
    logic [1:0]   resp_type;
    logic [5:0]   exp_index;
    logic         busy;
    logic         done;
    logic [5:0]   resp_index;
    logic [127:0] resp_data;
    logic         timeout_err;
    logic         crc_err;
    logic         frame_err;
    logic         index_err;

`ifdef SD_CMD_RESP_INDEX_CHECK_EN
    localparam logic IDX_EN = 1'b1;
`else
    localparam logic IDX_EN = 1'b0;
`endif

    localparam logic [119:0] CID = 120'h7E4456BFAFE53C7AB12900000ECD;

    typedef struct {
        logic [127:0] data;
        logic [5:0]   idx;
        logic         tmo;
        logic         crc;
        logic         frm;
        logic         ierr;
        logic         chk_data;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   done_cnt = 0;

    sd_cmd_resp_rx dut (
        .clk         (clk),
        .resetn      (resetn),
        .sd_clk_en   (sd_clk_en),
        .cmd_pin     (cmd_pin),
        .arm         (arm),
        .abort       (abort),
        .resp_type   (resp_type),
        .exp_index   (exp_index),
        .busy        (busy),
        .done        (done),
        .resp_index  (resp_index),
        .resp_data   (resp_data),
        .timeout_err (timeout_err),
        .crc_err     (crc_err),
        .frame_err   (frame_err),
        .index_err   (index_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference CRC7 by polynomial long division over the 120 CID bits.
    function automatic logic [6:0] crc7_model(input logic [119:0] d);
        logic [126:0] m;
        m = {d, 7'd0};
        for (int i = 126; i >= 7; i--) begin
            if (m[i]) m[i-:8] = m[i-:8] ^ 8'h89;
        end
        return m[6:0];
    endfunction

    task automatic push_exp(input logic [127:0] d, input logic [5:0] ix, input logic t,
                            input logic c, input logic f, input logic ie, input logic cd);
        exp_t e;
        e.data = d; e.idx = ix; e.tmo = t; e.crc = c; e.frm = f; e.ierr = ie; e.chk_data = cd;
        sb_q.push_back(e);
    endtask

    // One SD clock period: drive the line, then strobe 3 clks later.
    task automatic sd_bit(input logic b);
        @(negedge clk);
        cmd_pin   = b;
        sd_clk_en = 1'b0;
        repeat (3) @(negedge clk);
        sd_clk_en = 1'b1;
        @(negedge clk);
        sd_clk_en = 1'b0;
    endtask

    task automatic send_frame(input logic [135:0] f, input int len);
        for (int i = len - 1; i >= 0; i--) sd_bit(f[i]);
    endtask

    task automatic arm_pulse(input logic [1:0] t, input logic [5:0] ei);
        @(negedge clk);
        resp_type = t;
        exp_index = ei;
        arm       = 1'b1;
        @(negedge clk);
        arm       = 1'b0;
    endtask

    // End bit was just sampled: done must appear exactly one clk later.
    task automatic finish_frame(input string tag);
        check_eq({tag, "_done_early"}, done, 1'b0);
        @(negedge clk);
        check_eq({tag, "_done_lat"}, done, 1'b1);
        check_eq({tag, "_busy_end"}, busy, 1'b0);
    endtask

    task automatic rx48(input string tag, input logic [1:0] t, input logic [5:0] ei,
                        input logic [47:0] fr, input logic [31:0] earg, input logic [5:0] eidx,
                        input logic ecrc, input logic eierr);
        logic [135:0] f;
        f = 136'd0;
        f[47:0] = fr;
        arm_pulse(t, ei);
        check_eq({tag, "_busy"}, busy, 1'b1);
        push_exp({96'd0, earg}, eidx, 1'b0, ecrc, 1'b0, eierr, 1'b1);
        sd_bit(1'b1);
        sd_bit(1'b1);
        send_frame(f, 48);
        finish_frame(tag);
    endtask

    task automatic rx136(input string tag, input logic [119:0] cid_tx, input logic [6:0] crc,
                         input logic ecrc);
        logic [135:0] f;
        f = {1'b0, 1'b0, 6'h3F, cid_tx, crc, 1'b1};
        arm_pulse(2'd2, 6'd0);
        push_exp({cid_tx, crc, 1'b0}, 6'h3F, 1'b0, ecrc, 1'b0, 1'b0, 1'b1);
        sd_bit(1'b1);
        send_frame(f, 136);
        finish_frame(tag);
    endtask

    // Scoreboard: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (resetn && done) begin
            done_cnt++;
            check_eq("done_expected", (sb_q.size() > 0), 1'b1);
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                check_eq("timeout_err", timeout_err, mon_e.tmo);
                check_eq("crc_err", crc_err, mon_e.crc);
                check_eq("frame_err", frame_err, mon_e.frm);
                check_eq("index_err", index_err, mon_e.ierr);
                if (mon_e.chk_data) begin
                    check_eq("resp_data", resp_data, mon_e.data);
                    check_eq("resp_index", resp_index, mon_e.idx);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0]   cid_crc;
        logic [135:0] f;
        int           n0;

        resetn = 1'b0; sd_clk_en = 1'b0; cmd_pin = 1'b1; arm = 1'b0; abort = 1'b0;
        resp_type = 2'd0; exp_index = 6'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_data", resp_data, 128'd0);
        check_eq("rst_index", resp_index, 6'd0);
        check_eq("rst_flags", {timeout_err, crc_err, frame_err, index_err}, 4'd0);
        resetn = 1'b1;
        repeat (4) @(negedge clk);

        // Type 0: immediate done, never busy
        push_exp(128'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        arm_pulse(2'd0, 6'd0);
        check_eq("none_done", done, 1'b1);
        check_eq("none_busy", busy, 1'b0);
        @(negedge clk);

        rx48("r1",     2'd1, 6'd55, 48'h37_00000120_83, 32'h0000_0120, 6'h37, 1'b0, 1'b0);
        rx48("r7",     2'd1, 6'd8,  48'h08_000001AA_13, 32'h0000_01AA, 6'h08, 1'b0, 1'b0);
        rx48("r7_bad", 2'd1, 6'd8,  48'h08_000001AA_15, 32'h0000_01AA, 6'h08, 1'b1, 1'b0);
        rx48("r3",     2'd3, 6'd0,  48'h3F_80FF8000_FF, 32'h80FF_8000, 6'h3F, 1'b0, 1'b0);

        cid_crc = crc7_model(CID);
        rx136("r2", CID, cid_crc, 1'b0);
        check_eq("r2_cid", resp_data[127:8], CID);
        rx136("r2_bad", CID ^ (120'd1 << 77), cid_crc, 1'b1);

        // Timeout: no done through 63 strobes, done on the 64th
        arm_pulse(2'd1, 6'd55);
        push_exp(128'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n0 = done_cnt;
        repeat (63) sd_bit(1'b1);
        check_eq("tmo_early", done_cnt - n0, 0);
        check_eq("tmo_busy_wait", busy, 1'b1);
        sd_bit(1'b1);
        check_eq("tmo_done", done, 1'b1);
        check_eq("tmo_busy_end", busy, 1'b0);
        @(negedge clk);

        // Start bit on the 63rd strobe still receives normally
        arm_pulse(2'd1, 6'd55);
        push_exp({96'd0, 32'h0000_0120}, 6'h37, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (62) sd_bit(1'b1);
        f = 136'd0;
        f[47:0] = 48'h37_00000120_83;
        send_frame(f, 48);
        finish_frame("late_start");

        // Abort after 20 frame bits: no done, busy drops next clk
        arm_pulse(2'd1, 6'd55);
        sd_bit(1'b1);
        for (int i = 47; i >= 28; i--) sd_bit(f[i]);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("abort_busy", busy, 1'b0);
        n0 = done_cnt;
        for (int i = 27; i >= 0; i--) sd_bit(f[i]);
        sd_bit(1'b1);
        check_eq("abort_no_done", done_cnt - n0, 0);

        // Re-arm; a second arm while busy must be ignored
        arm_pulse(2'd1, 6'd55);
        push_exp({96'd0, 32'h0000_0120}, 6'h37, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        sd_bit(1'b1);
        arm_pulse(2'd0, 6'd0);
        check_eq("arm_busy_ignored", busy, 1'b1);
        sd_bit(1'b1);
        send_frame(f, 48);
        finish_frame("rearm");

        // Index mismatch: flagged only when the index check is built in
        rx48("idx_mis", 2'd1, 6'd41, 48'h37_00000120_83, 32'h0000_0120, 6'h37, 1'b0, IDX_EN);

        repeat (4) @(negedge clk);
        check_eq("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
